ula_arbitro: RTL and testbench

Two-requester arbiter and sequencer for the shared 6-bit ULA. It accepts operation requests (A, B, Sel) from two independent masters and grants the ULA to one of them, round-robin or fixed priority. The block holds the winning operands in registers while the ULA evaluates. It returns the registered result and flags, tagged with the requester id, over a valid/ack handshake. It instantiates the ULA internally and is the only driver of its inputs.

---
 rtl/ula_arbitro.sv | 178 +++++++++++++++++
 tb/tb_ula_arbitro.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbitro.sv
// Two-requester arbiter/sequencer around the shared 6-bit ULA: grants one master,
// holds its operands, and returns the registered result over a valid/ack handshake.

module ula (
   input  logic       Reset,
   input  logic [5:0] A,
   input  logic [5:0] B,
   input  logic [3:0] Sel,
   output logic [5:0] O,
   output logic       Overflow,
   output logic       Zero
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      O        = '0;
      Overflow = 1'b0;
      if (!Reset) begin
         if (!Sel[3]) begin
            // Arithmetic ops treat A/B as signed two's complement; Overflow is signed overflow.
            case (Sel[2:0])
               3'd0: begin O = A + B;      Overflow = (A[5] == B[5]) && (O[5] != A[5]); end
               3'd1: begin O = A - B;      Overflow = (A[5] != B[5]) && (O[5] != A[5]); end
               3'd2: begin O = A + 6'd1;   Overflow = (A == 6'h1F); end
               3'd3: begin O = A - 6'd1;   Overflow = (A == 6'h20); end
               3'd4: begin O = 6'd0 - A;   Overflow = (A == 6'h20); end
               3'd5: begin O = {A[4:0], 1'b0}; Overflow = A[5] ^ A[4]; end
               3'd6: O = {A[5], A[5:1]};
               default: O = B;
            endcase
         end else begin
            case (Sel[2:0])
               3'd0: O = A & B;
               3'd1: O = A | B;
               3'd2: O = A ^ B;
               3'd3: O = ~A;
               3'd4: O = ~(A & B);
               3'd5: O = ~(A | B);
               3'd6: O = ~(A ^ B);
               default: O = A;
            endcase
         end
      end
   end

   assign Zero = !Reset && (O == 6'd0);

endmodule

module ula_arbitro #(
   parameter bit PRIO_FIXA = 1'b0
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Req0,
   input  logic       Req1,
   input  logic [5:0] A0,
   input  logic [5:0] B0,
   input  logic [5:0] A1,
   input  logic [5:0] B1,
   input  logic [3:0] Sel0,
   input  logic [3:0] Sel1,
   input  logic       Res_Ack,
   output logic       Gnt0,
   output logic       Gnt1,
   output logic       Res_Valid,
   output logic       Res_Id,
   output logic [5:0] Res_O,
   output logic       Res_Overflow,
   output logic       Res_Zero,
   output logic       Busy,
   output logic [7:0] Ops0,
   output logic [7:0] Ops1
);

   typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

   estado_t    state_q, state_d;
   logic [5:0] op_a_q, op_b_q;
   logic [3:0] op_sel_q;
   logic       ult_q;
   logic       res_id_q, res_valid_q, res_ovf_q, res_zero_q;
   logic [5:0] res_o_q;
   logic [7:0] ops0_q, ops1_q;

   logic       any_req, win_id;
   logic [1:0] gnt;
   logic       ula_rst;
   logic [5:0] ula_o;
   logic       ula_ovf, ula_zero;

   assign ula_rst = ~Reset;

   ula u_ula (
      .Reset    (ula_rst),
      .A        (op_a_q),
      .B        (op_b_q),
      .Sel      (op_sel_q),
      .O        (ula_o),
      .Overflow (ula_ovf),
      .Zero     (ula_zero)
   );

   // Contention goes to requester 0 under fixed priority, otherwise to whoever did not win last.
   assign any_req = Req0 | Req1;
   assign win_id  = Req0 ? (Req1 && !PRIO_FIXA && !ult_q) : 1'b1;

   always_comb begin
      state_d = state_q;
      gnt     = 2'b00;
      case (state_q)
         OCIOSO: begin
            if (any_req) begin
               gnt     = win_id ? 2'b10 : 2'b01;
               state_d = EXECUTA;
            end
         end
         EXECUTA:  state_d = RESPONDE;
         RESPONDE: if (Res_Ack) state_d = OCIOSO;
         default:  state_d = OCIOSO;
      endcase
   end

   // Reset parks the FSM in OCIOSO, so grants are masked to keep them low while Reset is held.
   assign Gnt0 = gnt[0] & Reset;
   assign Gnt1 = gnt[1] & Reset;
   assign Busy = (state_q != OCIOSO);

   // NOTE: asynchronous active-low reset on every register; non-blocking assignments only.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= OCIOSO;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_sel_q    <= '0;
         ult_q       <= 1'b1;
         res_id_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_o_q     <= '0;
         res_ovf_q   <= 1'b0;
         res_zero_q  <= 1'b0;
         ops0_q      <= '0;
         ops1_q      <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            OCIOSO: begin
               if (any_req) begin
                  op_a_q   <= win_id ? A1 : A0;
                  op_b_q   <= win_id ? B1 : B0;
                  op_sel_q <= win_id ? Sel1 : Sel0;
                  res_id_q <= win_id;
                  ult_q    <= win_id;
               end
            end
            EXECUTA: begin
               res_o_q     <= ula_o;
               res_ovf_q   <= ula_ovf;
               res_zero_q  <= ula_zero;
               res_valid_q <= 1'b1;
               if (res_id_q) ops1_q <= ops1_q + 8'd1;
               else          ops0_q <= ops0_q + 8'd1;
            end
            RESPONDE: if (Res_Ack) res_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign Res_Valid    = res_valid_q;
   assign Res_Id       = res_id_q;
   assign Res_O        = res_o_q;
   assign Res_Overflow = res_ovf_q;
   assign Res_Zero     = res_zero_q;
   assign Ops0         = ops0_q;
   assign Ops1         = ops1_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Randomized lockstep bench for ula_arbitro: a round-robin and a fixed-priority
// instance, each compared every cycle against a transaction-level reference model.

module tb_ula_arbitro;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       req0 [2], req1 [2], ack [2];
   logic [5:0] a0 [2], b0 [2], a1 [2], b1 [2];
   logic [3:0] sel0 [2], sel1 [2];
   logic       gnt0 [2], gnt1 [2], vld [2], rid [2], ovf [2], zro [2], busy [2];
   logic [5:0] res [2];
   logic [7:0] ops0 [2], ops1 [2];

   ula_arbitro #(.PRIO_FIXA(1'b0)) u_rr (
      .Clock(clk), .Reset(rst_n), .Req0(req0[0]), .Req1(req1[0]),
      .A0(a0[0]), .B0(b0[0]), .A1(a1[0]), .B1(b1[0]), .Sel0(sel0[0]), .Sel1(sel1[0]),
      .Res_Ack(ack[0]), .Gnt0(gnt0[0]), .Gnt1(gnt1[0]), .Res_Valid(vld[0]), .Res_Id(rid[0]),
      .Res_O(res[0]), .Res_Overflow(ovf[0]), .Res_Zero(zro[0]), .Busy(busy[0]),
      .Ops0(ops0[0]), .Ops1(ops1[0])
   );

   ula_arbitro #(.PRIO_FIXA(1'b1)) u_fx (
      .Clock(clk), .Reset(rst_n), .Req0(req0[1]), .Req1(req1[1]),
      .A0(a0[1]), .B0(b0[1]), .A1(a1[1]), .B1(b1[1]), .Sel0(sel0[1]), .Sel1(sel1[1]),
      .Res_Ack(ack[1]), .Gnt0(gnt0[1]), .Gnt1(gnt1[1]), .Res_Valid(vld[1]), .Res_Id(rid[1]),
      .Res_O(res[1]), .Res_Overflow(ovf[1]), .Res_Zero(zro[1]), .Busy(busy[1]),
      .Ops0(ops0[1]), .Ops1(ops1[1])
   );

   // Reference model: m_st 0 = idle, 1 = operation held, 2 = result offered.
   int         m_st [2];
   bit         m_ult [2], m_id [2], m_valid [2], m_ov [2], m_z [2], p_ov [2], p_z [2];
   logic [5:0] m_o [2], p_o [2];
   int         m_ops0 [2], m_ops1 [2], done0 [2];
   bit         m_gr0 [2], m_gr1 [2];

   int p_req0 = 0, p_req1 = 0, p_ack = 0;
   int n_checks = 0, n_errors = 0;
   int cyc = 0;
   int gseq_id [$];
   int gseq_cyc [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Standalone ULA behaviour from signed integer arithmetic and bitwise logic.
   task automatic ula_ref(input logic [5:0] a, input logic [5:0] b, input logic [3:0] sel,
                          output logic [5:0] o, output bit ov, output bit z);
      int sa, sb, r;
      sa = $signed(a);
      sb = $signed(b);
      r  = 0;
      ov = 1'b0;
      if (!sel[3]) begin
         case (sel[2:0])
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = sa + 1;
            3'd3: r = sa - 1;
            3'd4: r = -sa;
            3'd5: r = sa * 2;
            3'd6: r = sa >>> 1;
            default: r = sb;
         endcase
         ov = (r > 31) || (r < -32);
         o  = 6'(r);
      end else begin
         case (sel[2:0])
            3'd0: o = a & b;
            3'd1: o = a | b;
            3'd2: o = a ^ b;
            3'd3: o = ~a;
            3'd4: o = ~(a & b);
            3'd5: o = ~(a | b);
            3'd6: o = ~(a ^ b);
            default: o = a;
         endcase
      end
      z = (o == 6'd0);
   endtask

   function automatic bit winner(input int k);
      if (req0[k] && req1[k]) return (k == 1) ? 1'b0 : !m_ult[k];
      return req0[k] ? 1'b0 : 1'b1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_ult[k] = 1'b1; m_id[k] = 1'b0; m_valid[k] = 1'b0;
         m_o[k] = '0; m_ov[k] = 1'b0; m_z[k] = 1'b0;
         m_ops0[k] = 0; m_ops1[k] = 0; done0[k] = 0;
         m_gr0[k] = 1'b0; m_gr1[k] = 1'b0;
      end
   endtask

   task automatic model_update(input int k);
      bit w;
      m_gr0[k] = 1'b0;
      m_gr1[k] = 1'b0;
      case (m_st[k])
         0: if (req0[k] || req1[k]) begin
            w = winner(k);
            if (w) begin
               m_gr1[k] = 1'b1;
               ula_ref(a1[k], b1[k], sel1[k], p_o[k], p_ov[k], p_z[k]);
            end else begin
               m_gr0[k] = 1'b1;
               ula_ref(a0[k], b0[k], sel0[k], p_o[k], p_ov[k], p_z[k]);
            end
            m_ult[k] = w;
            m_id[k]  = w;
            m_st[k]  = 1;
         end
         1: begin
            m_valid[k] = 1'b1;
            m_o[k] = p_o[k]; m_ov[k] = p_ov[k]; m_z[k] = p_z[k];
            if (m_id[k]) m_ops1[k] = (m_ops1[k] + 1) % 256;
            else begin
               m_ops0[k] = (m_ops0[k] + 1) % 256;
               done0[k]++;
            end
            m_st[k] = 2;
         end
         default: if (ack[k]) begin
            m_valid[k] = 1'b0;
            m_st[k]    = 0;
         end
      endcase
   endtask

   task automatic check_all(input int k);
      string n;
      bit eg0, eg1;
      n   = (k == 1) ? "fx" : "rr";
      eg0 = (m_st[k] == 0) && (req0[k] || req1[k]) && !winner(k);
      eg1 = (m_st[k] == 0) && (req0[k] || req1[k]) && winner(k);
      check({n, " gnt0"}, gnt0[k], eg0);
      check({n, " gnt1"}, gnt1[k], eg1);
      check({n, " res_valid"}, vld[k], m_valid[k]);
      check({n, " res_id"}, rid[k], m_id[k]);
      check({n, " res_o"}, res[k], m_o[k]);
      check({n, " res_ovf"}, ovf[k], m_ov[k]);
      check({n, " res_zero"}, zro[k], m_z[k]);
      check({n, " busy"}, busy[k], m_st[k] != 0);
      check({n, " ops0"}, ops0[k], m_ops0[k]);
      check({n, " ops1"}, ops1[k], m_ops1[k]);
   endtask

   task automatic check_reset(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, " gnt0"}, gnt0[k], 0);
         check({tag, " gnt1"}, gnt1[k], 0);
         check({tag, " res_valid"}, vld[k], 0);
         check({tag, " res_id"}, rid[k], 0);
         check({tag, " res_o"}, res[k], 0);
         check({tag, " res_ovf"}, ovf[k], 0);
         check({tag, " res_zero"}, zro[k], 0);
         check({tag, " busy"}, busy[k], 0);
         check({tag, " ops0"}, ops0[k], 0);
         check({tag, " ops1"}, ops1[k], 0);
      end
   endtask

   // One clock: drive at the falling edge, compare 1 ns later, advance the model.
   task automatic step();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!req0[k] || m_gr0[k]) begin
            req0[k] = ($urandom_range(99) < p_req0);
            if (req0[k]) begin
               a0[k] = 6'($urandom_range(63)); b0[k] = 6'($urandom_range(63));
               sel0[k] = 4'($urandom_range(15));
            end
         end
         if (!req1[k] || m_gr1[k]) begin
            req1[k] = ($urandom_range(99) < p_req1);
            if (req1[k]) begin
               a1[k] = 6'($urandom_range(63)); b1[k] = 6'($urandom_range(63));
               sel1[k] = 4'($urandom_range(15));
            end
         end
         ack[k] = ($urandom_range(99) < p_ack);
      end
      #1;
      check_all(0);
      check_all(1);
      if (gnt0[0] || gnt1[0]) begin
         gseq_id.push_back(gnt1[0] ? 1 : 0);
         gseq_cyc.push_back(cyc);
      end
      model_update(0);
      model_update(1);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req0[k] = 1'b0; req1[k] = 1'b0; ack[k] = 1'b0;
      end
      model_reset();
      #1;
      check_reset("reset");
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] eo;
      bit         eov, ez, seen;
      int         guard;

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req0[k] = 1'b0; req1[k] = 1'b0; ack[k] = 1'b0;
         a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0; sel0[k] = '0; sel1[k] = '0;
      end
      model_reset();
      repeat (3) @(posedge clk);

      // Single request straight out of reset; grant must stay masked while reset is held.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         req0[k] = 1'b1; a0[k] = 6'd5; b0[k] = 6'd3; sel0[k] = 4'b0000;
      end
      #1;
      check("reset masks gnt0", gnt0[0], 0);
      p_req0 = 0; p_req1 = 0; p_ack = 0;
      release_reset();
      step();
      check("single gnt0 first cycle", gnt0[0], 1);
      step();
      step();
      ula_ref(6'd5, 6'd3, 4'b0000, eo, eov, ez);
      check("single res_valid", vld[0], 1);
      check("single res_id", rid[0], 0);
      check("single res_o", res[0], eo);
      check("single res_ovf", ovf[0], eov);
      check("single res_zero", zro[0], ez);
      check("single ops0", ops0[0], 1);
      p_ack = 100;
      step();

      // Both requesters busy with ack tied high.
      do_reset();
      release_reset();
      gseq_id.delete();
      gseq_cyc.delete();
      cyc = 0;
      p_req0 = 100; p_req1 = 100; p_ack = 100;
      repeat (12) step();
      check("rr grant count", gseq_id.size(), 4);
      for (int i = 0; i < 4 && i < gseq_id.size(); i++) begin
         check($sformatf("rr grant %0d id", i), gseq_id[i], i % 2);
         check($sformatf("rr grant %0d cycle", i), gseq_cyc[i], 3 * i);
      end
      check("rr ops0 after 4", ops0[0], 2);
      check("rr ops1 after 4", ops1[0], 2);
      check("fx ops0 after 4", ops0[1], 4);
      check("fx ops1 after 4", ops1[1], 0);
      p_req0 = 0;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         step();
         seen = gnt1[1];
      end
      check("fx req1 wins after drop", seen, 1);

      // Back-pressure: result held for 10 cycles while requester 1 waits.
      do_reset();
      release_reset();
      p_req0 = 0; p_req1 = 100; p_ack = 0;
      guard = 0;
      while (!m_valid[0] && guard < 10) begin
         step();
         guard++;
      end
      repeat (10) step();
      check("bp busy", busy[0], 1);
      check("bp gnt1 held", gnt1[0], 0);
      check("bp res_valid", vld[0], 1);
      p_ack = 100;
      step();
      step();
      check("bp gnt1 after ack", gnt1[0], 1);

      // Logic operation on zero operands.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         req1[k] = 1'b1; a1[k] = 6'h00; b1[k] = 6'h00; sel1[k] = 4'b1000;
      end
      p_req0 = 0; p_req1 = 0; p_ack = 0;
      release_reset();
      repeat (3) step();
      ula_ref(6'h00, 6'h00, 4'b1000, eo, eov, ez);
      for (int k = 0; k < 2; k++) begin
         check("logic res_ovf", ovf[k], 0);
         check("logic res_o", res[k], eo);
         check("logic res_zero", zro[k], eo == 6'd0);
         check("logic res_id", rid[k], 1);
      end

      // Randomized traffic.
      do_reset();
      release_reset();
      p_req0 = 60; p_req1 = 60; p_ack = 50;
      repeat (1500) step();

      // Asynchronous reset in the middle of EXECUTA.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         req0[k] = 1'b1; a0[k] = 6'd9; b0[k] = 6'd7; sel0[k] = 4'b0001;
      end
      p_req0 = 0; p_req1 = 0; p_ack = 0;
      release_reset();
      step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async");
      model_reset();
      release_reset();
      repeat (3) step();

      // Counter wrap after 256 completions on requester 0.
      do_reset();
      release_reset();
      p_req0 = 100; p_req1 = 0; p_ack = 100;
      guard = 0;
      while (done0[0] < 256 && guard < 2000) begin
         step();
         guard++;
      end
      step();
      check("rr ops0 wrap", ops0[0], 0);
      check("fx ops0 wrap", ops0[1], 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
